// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: arm, wait for trigger (or optional timeout), gate samples into memory, report done.
// Latency: capture_go rises one cycle after CAPTURE entry; capture_done pulses on the cycle capture_go falls.
// Backpressure: mem_stop ends an active capture after counting the current sample; ignored outside CAPTURE.
// Optional feature: define ADC_CAPTURE_TIMEOUT_EN to force a trigger after timeout_cycles spent in ARMED.
module adc_capture_ctrl #(
    parameter int CNT_WIDTH = 32,
    parameter int TMO_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_arm,
    input  logic                 trigger,
    input  logic                 trigger_mode,
    input  logic                 trigger_wait,
    input  logic [CNT_WIDTH-1:0] sample_count,
    input  logic [TMO_WIDTH-1:0] timeout_cycles,
    input  logic                 mem_stop,
    output logic                 armed,
    output logic                 capture_go,
    output logic                 capture_done,
    output logic [CNT_WIDTH-1:0] sample_cnt,
    output logic                 timeout_fired,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_INACT = 3'd1,
        ARMED      = 3'd2,
        CAPTURE    = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt_lat, cnt_lat_nxt;
    logic [CNT_WIDTH-1:0] sample_cnt_nxt;
    logic                 armed_nxt, capture_go_nxt, capture_done_nxt;

    logic                 trig_act;
    logic                 tmo_hit;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 cnt_last;
    logic                 cnt_sat;

    assign trig_act = (trigger == trigger_mode);
    assign cnt_inc  = sample_cnt + CNT_WIDTH'(1);
    // A latched count of zero means unlimited, so it never matches.
    assign cnt_last = (cnt_lat != '0) && (cnt_inc == cnt_lat);
    assign cnt_sat  = &sample_cnt;
    assign state_o  = state;

`ifdef ADC_CAPTURE_TIMEOUT_EN
    logic [TMO_WIDTH-1:0] tmo_cnt;
    logic                 tmo_start;

    // Fire on the edge where the counter would reach timeout_cycles, i.e. timeout_cycles edges after ARMED entry.
    assign tmo_hit   = (timeout_cycles != '0) && ((tmo_cnt + TMO_WIDTH'(1)) == timeout_cycles);
    // ARMED->CAPTURE without an active trigger can only be the timeout; a coincident real trigger wins.
    assign tmo_start = (state == ARMED) && (state_nxt == CAPTURE) && !trig_act;

    // Cycle counter for the forced trigger, restarted on every entry to ARMED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if ((state_nxt == ARMED) && (state != ARMED)) begin
            tmo_cnt <= '0;
        end else if (state == ARMED) begin
            tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
        end
    end

    // Sticky flag: set by a timeout-started capture, cleared when a new arm sequence begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_fired <= 1'b0;
        end else if ((state == IDLE) && (state_nxt != IDLE)) begin
            timeout_fired <= 1'b0;
        end else if (tmo_start) begin
            timeout_fired <= 1'b1;
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit       = 1'b0;
    assign timeout_fired = 1'b0;
    assign unused_tmo    = ^timeout_cycles;
`endif

    // State register and registered outputs; reset aborts any capture without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt_lat      <= '0;
            sample_cnt   <= '0;
            armed        <= 1'b0;
            capture_go   <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt_lat      <= cnt_lat_nxt;
            sample_cnt   <= sample_cnt_nxt;
            armed        <= armed_nxt;
            capture_go   <= capture_go_nxt;
            capture_done <= capture_done_nxt;
        end
    end

    // Next-state and next-output decode; abort beats trigger, the first CAPTURE cycle only opens the gate.
    always_comb begin
        state_nxt        = state;
        cnt_lat_nxt      = cnt_lat;
        sample_cnt_nxt   = sample_cnt;
        capture_go_nxt   = 1'b0;
        capture_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_arm) begin
                    state_nxt = trigger_wait ? WAIT_INACT : ARMED;
                end
            end
            WAIT_INACT: begin
                if (!cmd_arm) begin
                    state_nxt = IDLE;
                end else if (!trig_act) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (!cmd_arm) begin
                    state_nxt = IDLE;
                end else if (trig_act || tmo_hit) begin
                    state_nxt      = CAPTURE;
                    cnt_lat_nxt    = sample_count;
                    sample_cnt_nxt = '0;
                end
            end
            CAPTURE: begin
                capture_go_nxt = 1'b1;
                if (capture_go) begin
                    if (!cnt_sat) begin
                        sample_cnt_nxt = cnt_inc;
                    end
                    if (cnt_last || mem_stop) begin
                        state_nxt        = DONE;
                        capture_go_nxt   = 1'b0;
                        capture_done_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!cmd_arm) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        armed_nxt = (state_nxt == ARMED);
    end

endmodule
